// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the mem_lsu load/store unit.
// Size codes, FSM state codes, per-size byte masks and load extension.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC1 = 2'd1;
  localparam logic [1:0] ST_ACC2 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_mask = MASK_BYTE;
      SZ_HALF: size_mask = MASK_HALF;
      SZ_WORD: size_mask = MASK_WORD;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  // Truncate right-justified load data to the access size, then zero/sign extend.
  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] sz,
                                              input logic uns);
    case (sz)
      SZ_BYTE: extend_load = {{24{~uns & d[7]}}, d[7:0]};
      SZ_HALF: extend_load = {{16{~uns & d[15]}}, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// CPU request/response and data-memory bus of the load/store unit.
// The LSU is the slave of the CPU side and drives the memory side.
interface mem_lsu_if #(parameter int ADDR_W = 32);
  logic              i_req;
  logic              o_ready;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [31:0]       i_wdata;
  logic              o_valid;
  logic              o_err;
  logic [31:0]       o_rdata;
  logic [ADDR_W-3:0] o_mem_address;
  logic [3:0]        o_mem_sel_width;
  logic              o_mem_w_en;
  logic [31:0]       o_mem_din;
  logic [31:0]       i_mem_dout;

  modport slave (
    input  i_req, i_we, i_addr, i_size, i_unsigned, i_wdata, i_mem_dout,
    output o_ready, o_valid, o_err, o_rdata,
           o_mem_address, o_mem_sel_width, o_mem_w_en, o_mem_din
  );

  modport master (
    output i_req, i_we, i_addr, i_size, i_unsigned, i_wdata, i_mem_dout,
    input  o_ready, o_valid, o_err, o_rdata,
           o_mem_address, o_mem_sel_width, o_mem_w_en, o_mem_din
  );
endinterface

// File: rtl/mem_lsu_lane.sv
// Byte-lane select and data shift amount for the first or second word of an access.
// Shared by the write-data alignment and read-data assembly paths.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_offset,
  input  logic       i_second,
  output logic [3:0] o_sel,
  output logic [4:0] o_shift
);

  logic [7:0] wide;
  logic [1:0] rem;

  always_comb begin
    // Upper nibble of the shifted mask holds the lanes spilling into the next word.
    wide = {4'b0000, size_mask(i_size)} << i_offset;
    rem  = 2'd0 - i_offset;
    if (i_second) begin
      o_sel   = wide[7:4];
      o_shift = {rem, 3'b000};
    end else begin
      o_sel   = wide[3:0];
      o_shift = {i_offset, 3'b000};
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-addressed, async-read/sync-write data memory.
// Define MEM_LSU_MISALIGN_SPLIT_EN to allow misaligned accesses split over two words.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic      i_clk,
  input logic      i_rst,
  mem_lsu_if.slave bus
);

  localparam int WA_W = ADDR_W - 2;

  logic [1:0]        state_q, state_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;

  logic              legal;
  logic [2:0]        span;
  logic              crossing;
  logic [3:0]        lane_sel;
  logic [4:0]        lane_sh;
  logic [WA_W-1:0]   mem_addr;
  logic [3:0]        mem_sel;
  logic              mem_we;
  logic [31:0]       mem_din;

  mem_lsu_lane u_lane (
    .i_size   (size_q),
    .i_offset (addr_q[1:0]),
    .i_second (state_q == ST_ACC2),
    .o_sel    (lane_sel),
    .o_shift  (lane_sh)
  );

  always_comb begin
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
    legal = (bus.i_size != SZ_RSVD);
`else
    case (bus.i_size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~bus.i_addr[0];
      SZ_WORD: legal = (bus.i_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
`endif
  end

  assign span     = {1'b0, addr_q[1:0]} + size_bytes(size_q);
  assign crossing = (span > 3'd4);

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    asm_d    = asm_q;
    mem_addr = '0;
    mem_sel  = 4'b0000;
    mem_we   = 1'b0;
    mem_din  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req) begin
          we_d    = bus.i_we;
          addr_d  = bus.i_addr;
          size_d  = bus.i_size;
          uns_d   = bus.i_unsigned;
          wdata_d = bus.i_wdata;
          err_d   = ~legal;
          state_d = ST_ACC1;
        end
      end
      // Rejected requests idle through ACC1 with the memory bus quiet, so every
      // single-word completion, good or bad, lands at the same latency.
      ST_ACC1: begin
        if (!err_q) begin
          mem_addr = addr_q[ADDR_W-1:2];
          mem_sel  = lane_sel;
          mem_we   = we_q;
          mem_din  = wdata_q << lane_sh;
          asm_d    = bus.i_mem_dout >> lane_sh;
        end
        if (!err_q && crossing) begin
          state_d = ST_ACC2;
        end else begin
          state_d = ST_RESP;
          if (!err_q && !we_q) rdata_d = extend_load(asm_d, size_q, uns_q);
        end
      end
      ST_ACC2: begin
        mem_addr = addr_q[ADDR_W-1:2] + WA_W'(1);
        mem_sel  = lane_sel;
        mem_we   = we_q;
        mem_din  = wdata_q >> lane_sh;
        asm_d    = asm_q | (bus.i_mem_dout << lane_sh);
        state_d  = ST_RESP;
        if (!we_q) rdata_d = extend_load(asm_d, size_q, uns_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge i_clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
    asm_q   <= asm_d;
  end

  // Reset gates the write strobe immediately so an aborted store never commits.
  assign bus.o_mem_w_en      = mem_we & ~i_rst;
  assign bus.o_mem_sel_width = mem_sel;
  assign bus.o_mem_address   = mem_addr;
  assign bus.o_mem_din       = mem_din;
  assign bus.o_ready         = (state_q == ST_IDLE);
  assign bus.o_valid         = (state_q == ST_RESP);
  assign bus.o_err           = (state_q == ST_RESP) & err_q;
  assign bus.o_rdata         = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed scoreboard bench for mem_lsu with a small word-addressed memory model.
// Expectations follow the MEM_LSU_MISALIGN_SPLIT_EN setting of the build.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

`ifdef MEM_LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  logic [31:0] mem [16];
  logic        pl_we = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_data = 32'd0;

  mem_lsu_if #(.ADDR_W(32)) bus();

  mem_lsu #(.ADDR_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_we)
      mem[pl_idx] <= pl_data;
    else if (bus.o_mem_w_en)
      mem[bus.o_mem_address[3:0]] <= (mem[bus.o_mem_address[3:0]] & ~lanes(bus.o_mem_sel_width))
                                     | (bus.o_mem_din & lanes(bus.o_mem_sel_width));
  end

  always_comb bus.i_mem_dout = mem[bus.o_mem_address[3:0]] & lanes(bus.o_mem_sel_width);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [3:0] i, input logic [31:0] d);
    pl_idx  = i;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: o_ready still 0 after %0d cycles", n);
        return;
      end
    end
  endtask

  // Called at a negedge; ends at the negedge of the last memory access.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input bit hold,
                       input logic e_err, input logic [31:0] e_rdata, input int e_lat,
                       input bit split,
                       input logic [29:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                       input logic [29:0] a2, input logic [3:0] s2, input logic [31:0] d2,
                       output int acc);
    exp_t e;
    wait_ready();
    bus.i_we       = we;
    bus.i_addr     = addr;
    bus.i_size     = size;
    bus.i_unsigned = uns;
    bus.i_wdata    = wdata;
    bus.i_req      = 1'b1;
    acc = cyc;
    e.err = e_err; e.rdata = e_rdata; e.lat = e_lat; e.acc = acc;
    q.push_back(e);
    @(posedge clk);
    #1 if (!hold) bus.i_req = 1'b0;
    @(negedge clk);
    chk("acc1_addr", 32'(bus.o_mem_address), 32'(a1));
    chk("acc1_sel", 32'(bus.o_mem_sel_width), 32'(s1));
    chk("acc1_din", bus.o_mem_din, d1);
    chk("acc1_wen", 32'(bus.o_mem_w_en), 32'(we & ~e_err));
    chk("acc1_ready", 32'(bus.o_ready), 32'd0);
    if (split) begin
      @(negedge clk);
      chk("acc2_addr", 32'(bus.o_mem_address), 32'(a2));
      chk("acc2_sel", 32'(bus.o_mem_sel_width), 32'(s2));
      chk("acc2_din", bus.o_mem_din, d2);
      chk("acc2_wen", 32'(bus.o_mem_w_en), 32'(we & ~e_err));
    end
  endtask

  initial begin
    int acc;
    int n;
    logic [31:0] last;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 32'd0; bus.i_size = SZ_BYTE;
    bus.i_unsigned = 1'b0; bus.i_wdata = 32'd0;

    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && bus.o_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: o_valid=1 with no pending request (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            chk("resp_err", 32'(bus.o_err), 32'(e.err));
            chk("resp_rdata", bus.o_rdata, e.rdata);
            chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_wen", 32'(bus.o_mem_w_en), 32'd0);
    chk("rst_sel", 32'(bus.o_mem_sel_width), 32'd0);
    chk("rst_addr", 32'(bus.o_mem_address), 32'd0);
    chk("rst_din", bus.o_mem_din, 32'd0);
    rst = 1'b0;

    preload(4'd1, 32'h11223344);
    issue(1'b1, 32'h105, SZ_BYTE, 1'b0, 32'hAB, 1'b0, 1'b0, 32'd0, 2, 1'b0,
          30'h41, 4'b0010, 32'h0000AB00, 30'd0, 4'd0, 32'd0, acc);
    @(negedge clk);
    chk("mem_byte_store", mem[1], 32'h1122AB44);

    preload(4'd0, 32'h80FF1234);
    issue(1'b0, 32'h102, SZ_HALF, 1'b0, 32'd0, 1'b0, 1'b0, 32'hFFFF80FF, 2, 1'b0,
          30'h40, 4'b1100, 32'd0, 30'd0, 4'd0, 32'd0, acc);
    issue(1'b0, 32'h102, SZ_HALF, 1'b1, 32'd0, 1'b0, 1'b0, 32'h000080FF, 2, 1'b0,
          30'h40, 4'b1100, 32'd0, 30'd0, 4'd0, 32'd0, acc);
    issue(1'b0, 32'h101, SZ_BYTE, 1'b0, 32'd0, 1'b0, 1'b0, 32'h00000012, 2, 1'b0,
          30'h40, 4'b0010, 32'd0, 30'd0, 4'd0, 32'd0, acc);
    issue(1'b0, 32'h103, SZ_BYTE, 1'b0, 32'd0, 1'b0, 1'b0, 32'hFFFFFF80, 2, 1'b0,
          30'h40, 4'b1000, 32'd0, 30'd0, 4'd0, 32'd0, acc);
    issue(1'b0, 32'h103, SZ_BYTE, 1'b1, 32'd0, 1'b0, 1'b0, 32'h00000080, 2, 1'b0,
          30'h40, 4'b1000, 32'd0, 30'd0, 4'd0, 32'd0, acc);
    last = SPLIT ? 32'hFFFFFF12 : 32'h00000080;
    issue(1'b0, 32'h101, SZ_HALF, 1'b0, 32'd0, 1'b0, !SPLIT, last, 2, 1'b0,
          SPLIT ? 30'h40 : 30'd0, SPLIT ? 4'b0110 : 4'b0000, 32'd0, 30'd0, 4'd0, 32'd0, acc);

    wait_ready();
    preload(4'd0, 32'h11223344);
    preload(4'd1, 32'h55667788);
    issue(1'b0, 32'h200, SZ_WORD, 1'b0, 32'd0, 1'b0, 1'b0, 32'h11223344, 2, 1'b0,
          30'h80, 4'b1111, 32'd0, 30'd0, 4'd0, 32'd0, acc);
    last = SPLIT ? 32'h66778811 : 32'h11223344;
    issue(1'b0, 32'h203, SZ_WORD, 1'b0, 32'd0, 1'b0, !SPLIT, last, SPLIT ? 3 : 2, SPLIT,
          SPLIT ? 30'h80 : 30'd0, SPLIT ? 4'b1000 : 4'b0000, 32'd0,
          30'h81, 4'b0111, 32'd0, acc);
    issue(1'b1, 32'h300, SZ_RSVD, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, last, 2, 1'b0,
          30'd0, 4'd0, 32'd0, 30'd0, 4'd0, 32'd0, acc);
    @(negedge clk);
    chk("mem_rsvd_untouched", mem[0], 32'h11223344);

    wait_ready();
    preload(4'd15, 32'h00000000);
    preload(4'd0, 32'hFFFFFFFF);
    issue(1'b1, 32'hFFFFFFFE, SZ_WORD, 1'b0, 32'hA1B2C3D4, 1'b1, !SPLIT, last,
          SPLIT ? 3 : 2, SPLIT,
          SPLIT ? 30'h3FFFFFFF : 30'd0, SPLIT ? 4'b1100 : 4'b0000,
          SPLIT ? 32'hC3D40000 : 32'd0,
          30'd0, 4'b0011, 32'h0000A1B2, acc);
    n = 0;
    while (!bus.o_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return", 32'(cyc - acc), SPLIT ? 32'd4 : 32'd3);
    chk("mem_split_hi", mem[15], SPLIT ? 32'hC3D40000 : 32'h00000000);
    chk("mem_split_wrap", mem[0], SPLIT ? 32'hFFFFA1B2 : 32'hFFFFFFFF);
    last = SPLIT ? 32'hFFFFFFC3 : 32'h00000000;
    issue(1'b0, 32'hFFFFFFFF, SZ_BYTE, 1'b0, 32'd0, 1'b0, 1'b0, last, 2, 1'b0,
          30'h3FFFFFFF, 4'b1000, 32'd0, 30'd0, 4'd0, 32'd0, acc);

    wait_ready();
    bus.i_we = 1'b1; bus.i_addr = 32'h104; bus.i_size = SZ_BYTE;
    bus.i_unsigned = 1'b0; bus.i_wdata = 32'h5A; bus.i_req = 1'b1;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    @(negedge clk);
    chk("abort_acc1_wen", 32'(bus.o_mem_w_en), 32'd1);
    chk("abort_acc1_addr", 32'(bus.o_mem_address), 32'h41);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_wen", 32'(bus.o_mem_w_en), 32'd0);
    chk("abort_valid", 32'(bus.o_valid), 32'd0);
    chk("abort_ready", 32'(bus.o_ready), 32'd1);
    chk("abort_rdata", bus.o_rdata, 32'd0);
    chk("abort_mem", mem[1], 32'h55667788);

    issue(1'b0, 32'h104, SZ_WORD, 1'b0, 32'd0, 1'b0, 1'b0, 32'h55667788, 2, 1'b0,
          30'h41, 4'b1111, 32'd0, 30'd0, 4'd0, 32'd0, acc);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d responses never arrived", q.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
